// File: rtl/jpeg_dec_pkg.sv
// Shared types and tables for the JPEG decoder run-length / de-zigzag stage.
// ZIGZAG maps scan position k to the natural row-major coefficient index.
package jpeg_dec_pkg;

    typedef enum logic [1:0] {
        EXP_DC = 2'd0,
        EXP_AC = 2'd1,
        OUT    = 2'd2
    } state_e;

    // {run, size} codes for the two AC symbols that carry no amplitude
    localparam logic [7:0] EOB_CODE = 8'h00;
    localparam logic [7:0] ZRL_CODE = 8'hF0;

    localparam int MAX_DC_SIZE = 11;
    localparam int MAX_AC_SIZE = 10;

    localparam logic [5:0] ZIGZAG [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10,
        17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34,
        27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36,
        29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46,
        53, 60, 61, 54, 47, 55, 62, 63
    };

endpackage

// File: rtl/jpeg_amp_decode.sv
// JPEG amplitude decode: (size, raw bits) to a signed coefficient value.
// Arithmetic is done modulo 2^COEF_WIDTH, matching the wrapping DC predictor.
module jpeg_amp_decode
    import jpeg_dec_pkg::*;
#(
    parameter int COEF_WIDTH = 11
) (
    input  logic [3:0]                   size_i,
    input  logic [10:0]                  bits_i,
    output logic signed [COEF_WIDTH-1:0] value_o
);

    logic [COEF_WIDTH-1:0] mask;
    logic [COEF_WIDTH-1:0] mag;
    logic                  msb;

    always_comb begin
        mask    = COEF_WIDTH'((32'd1 << size_i) - 32'd1);
        mag     = COEF_WIDTH'(bits_i) & mask;
        // mask ^ (mask >> 1) isolates bit S-1 without a variable bit-select
        msb     = |(mag & (mask ^ (mask >> 1)));
        value_o = msb ? mag : mag - mask;
        if (size_i == 4'd0 || int'(size_i) > MAX_DC_SIZE) begin
            value_o = '0;
        end
    end

endmodule

// File: rtl/jpeg_rle_dezigzag.sv
// Rebuilds an 8x8 block of quantized coefficients from decoded DC/AC symbols
// and streams it out one natural-order row per handshake.
module jpeg_rle_dezigzag
    import jpeg_dec_pkg::*;
#(
    parameter int COEF_WIDTH = 11,
    parameter int NUM_COMP   = 3
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    sym_valid,
    output logic                    sym_ready,
    input  logic                    sym_is_dc,
    input  logic [1:0]              sym_comp,
    input  logic [3:0]              sym_run,
    input  logic [3:0]              sym_size,
    input  logic [10:0]             sym_bits,
    input  logic                    pred_clear,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2:0]              out_row,
    output logic                    out_last,
    output logic [8*COEF_WIDTH-1:0] out_data,
    output logic                    err
);

    typedef logic signed [COEF_WIDTH-1:0] coef_t;

    state_e      state_q, state_d;
    logic [6:0]  k_q, k_d;
    logic [2:0]  row_q, row_d;
    logic        err_q, err_d;
    logic        ready_q;
    logic [63:0] mask_q;
    coef_t       pred_q [NUM_COMP];
    coef_t       coef_q [64];

    coef_t       amp, dc_base, dc_new, wr_val;
    logic [6:0]  pos;
    logic [5:0]  wr_idx;
    logic        acc, wr_en, pred_we, mask_clr;

    jpeg_amp_decode #(.COEF_WIDTH(COEF_WIDTH)) u_amp (
        .size_i  (sym_size),
        .bits_i  (sym_bits),
        .value_o (amp)
    );

    assign sym_ready = ready_q & ~reset;
    assign acc       = sym_valid & sym_ready;
    assign pos       = k_q + {3'd0, sym_run};

    // An out-of-range component index predicts from 0 and is not stored
    always_comb begin
        dc_base = '0;
        for (int i = 0; i < NUM_COMP; i++) begin
            if (sym_comp == 2'(i) && !pred_clear) dc_base = pred_q[i];
        end
        dc_new = dc_base + amp;
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        row_d    = row_q;
        err_d    = err_q;
        wr_en    = 1'b0;
        wr_idx   = ZIGZAG[pos[5:0]];
        wr_val   = amp;
        pred_we  = 1'b0;
        mask_clr = 1'b0;
        case (state_q)
            EXP_DC: if (acc) begin
                if (sym_is_dc) begin
                    pred_we = 1'b1;
                    wr_en   = 1'b1;
                    wr_idx  = 6'd0;
                    wr_val  = dc_new;
                    k_d     = 7'd1;
                    state_d = EXP_AC;
                    if (int'(sym_size) > MAX_DC_SIZE) err_d = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            EXP_AC: if (acc) begin
                if (sym_is_dc) begin
                    err_d   = 1'b1;
                    state_d = OUT;
                end else if ({sym_run, sym_size} == EOB_CODE) begin
                    state_d = OUT;
                end else if ({sym_run, sym_size} == ZRL_CODE) begin
                    k_d = k_q + 7'd16;
                    if (k_q + 7'd16 >= 7'd64) begin
                        err_d   = 1'b1;
                        state_d = OUT;
                    end
                end else if (sym_size == 4'd0 || int'(sym_size) > MAX_AC_SIZE || pos > 7'd63) begin
                    err_d   = 1'b1;
                    state_d = OUT;
                end else begin
                    wr_en = 1'b1;
                    k_d   = pos + 7'd1;
                    if (pos == 7'd63) state_d = OUT;
                end
            end
            OUT: if (out_ready) begin
                row_d = row_q + 3'd1;
                if (row_q == 3'd7) begin
                    mask_clr = 1'b1;
                    k_d      = 7'd0;
                    state_d  = EXP_DC;
                end
            end
            default: state_d = EXP_DC;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= EXP_DC;
            k_q     <= '0;
            row_q   <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            mask_q  <= '0;
            for (int i = 0; i < NUM_COMP; i++) pred_q[i] <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            row_q   <= row_d;
            err_q   <= err_d;
            ready_q <= (state_d != OUT);
            if (mask_clr)   mask_q         <= '0;
            else if (wr_en) mask_q[wr_idx] <= 1'b1;
            for (int i = 0; i < NUM_COMP; i++) begin
                if (pred_we && sym_comp == 2'(i)) pred_q[i] <= dc_new;
                else if (pred_clear)              pred_q[i] <= '0;
            end
        end
    end

    // Stale contents are hidden by the mask, so the array needs no reset
    always_ff @(posedge clock) begin
        if (wr_en) coef_q[wr_idx] <= wr_val;
    end

    always_comb begin
        for (int c = 0; c < 8; c++) begin
            out_data[c*COEF_WIDTH +: COEF_WIDTH] =
                mask_q[{row_q, 3'(c)}] ? coef_q[{row_q, 3'(c)}] : '0;
        end
    end

    assign out_valid = (state_q == OUT);
    assign out_row   = row_q;
    assign out_last  = out_valid && (row_q == 3'd7);
    assign err       = err_q;

endmodule

// File: tb/tb_jpeg_rle_dezigzag.sv
// Directed bench: each block's expected rows are queued by the stimulus and
// checked by an independent output monitor.
module tb_jpeg_rle_dezigzag;

    localparam int CW = 11;

    logic          clock, reset;
    logic          sym_valid, sym_ready, sym_is_dc, pred_clear;
    logic [1:0]    sym_comp;
    logic [3:0]    sym_run, sym_size;
    logic [10:0]   sym_bits;
    logic          out_valid, out_ready, out_last, err;
    logic [2:0]    out_row;
    logic [8*CW-1:0] out_data;

    jpeg_rle_dezigzag #(.COEF_WIDTH(CW), .NUM_COMP(3)) dut (
        .clock(clock), .reset(reset),
        .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_is_dc(sym_is_dc),
        .sym_comp(sym_comp), .sym_run(sym_run), .sym_size(sym_size), .sym_bits(sym_bits),
        .pred_clear(pred_clear),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_last(out_last), .out_data(out_data), .err(err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]      row;
        logic [8*CW-1:0] data;
    } row_t;

    row_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   exp_c [64];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    function automatic logic [8*CW-1:0] row_data(input int r);
        logic [8*CW-1:0] d;
        for (int c = 0; c < 8; c++) d[c*CW +: CW] = CW'(exp_c[r*8 + c]);
        return d;
    endfunction

    task automatic clear_exp();
        for (int i = 0; i < 64; i++) exp_c[i] = 0;
    endtask

    task automatic push_rows(input int n);
        row_t e;
        for (int r = 0; r < n; r++) begin
            e.row  = 3'(r);
            e.data = row_data(r);
            q.push_back(e);
        end
    endtask

    task automatic send(input logic dc, input logic [1:0] comp, input logic [3:0] run,
                        input logic [3:0] size, input logic [10:0] bits, output int waited);
        sym_is_dc = dc; sym_comp = comp; sym_run = run; sym_size = size; sym_bits = bits;
        sym_valid = 1'b1;
        waited = 0;
        while (!sym_ready && waited < 50) begin
            @(posedge clock); #1;
            waited++;
        end
        if (!sym_ready) begin
            tests++; fails++;
            $display("FAIL sym_accept: sym_ready stuck at 0, expected 1");
        end else begin
            @(posedge clock); #1;
        end
        sym_valid = 1'b0;
    endtask

    task automatic dc_sym(input logic [1:0] comp, input logic [3:0] size, input logic [10:0] bits);
        int w;
        send(1'b1, comp, 4'd0, size, bits, w);
    endtask

    task automatic ac_sym(input logic [3:0] run, input logic [3:0] size, input logic [10:0] bits);
        int w;
        send(1'b0, 2'd0, run, size, bits, w);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (!(q.size() == 0 && !out_valid) && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        if (q.size() != 0 || out_valid) begin
            tests++; fails++;
            $display("FAIL drain_timeout: %0d rows pending, expected 0", q.size());
        end
    endtask

    task automatic wait_row(input logic [2:0] r);
        int n = 0;
        while (!(out_valid && out_row == r) && n < 40) begin
            @(posedge clock); #1;
            n++;
        end
        if (!(out_valid && out_row == r)) begin
            tests++; fails++;
            $display("FAIL wait_row: row %0d never presented, got row %0d", r, out_row);
        end
    endtask

    always @(negedge clock) begin
        row_t e;
        if (!reset && out_valid && out_ready) begin
            if (q.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_row: got row %0d, expected no output", out_row);
            end else begin
                e = q.pop_front();
                chk("row_index", 128'(out_row), 128'(e.row));
                chk("row_data", 128'(out_data), 128'(e.data));
                chk("row_last", 128'(out_last), 128'(e.row == 3'd7));
            end
        end
    end

    initial begin
        int w;
        logic [8*CW-1:0] bp_exp;
        reset = 1'b1; sym_valid = 1'b0; sym_is_dc = 1'b0; sym_comp = '0;
        sym_run = '0; sym_size = '0; sym_bits = '0; pred_clear = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_sym_ready", 128'(sym_ready), 128'(0));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_out_row", 128'(out_row), 128'(0));
        chk("rst_out_last", 128'(out_last), 128'(0));
        chk("rst_err", 128'(err), 128'(0));
        chk("rst_out_data", 128'(out_data), 128'(0));
        reset = 1'b0;
        @(posedge clock); #1;
        chk("first_sym_ready", 128'(sym_ready), 128'(1));

        // comp 0: +5 then -2 gives 3
        clear_exp(); exp_c[0] = 5; push_rows(8);
        dc_sym(2'd0, 4'd3, 11'b101); ac_sym(4'd0, 4'd0, 11'd0);
        wait_drain();
        chk("blk1_err", 128'(err), 128'(0));
        clear_exp(); exp_c[0] = 3; push_rows(8);
        dc_sym(2'd0, 4'd2, 11'b01); ac_sym(4'd0, 4'd0, 11'd0);
        wait_drain();

        // negative AC amplitudes at zigzag positions 1 and 3
        clear_exp(); exp_c[1] = -1; exp_c[16] = -9; push_rows(8);
        dc_sym(2'd2, 4'd0, 11'd0);
        ac_sym(4'd0, 4'd1, 11'b0); ac_sym(4'd1, 4'd4, 11'b0110); ac_sym(4'd0, 4'd0, 11'd0);
        wait_drain();

        // full block without EOB, next DC held across the whole drain
        clear_exp(); exp_c[63] = 1; push_rows(8);
        dc_sym(2'd2, 4'd0, 11'd0);
        repeat (3) ac_sym(4'd15, 4'd0, 11'd0);
        ac_sym(4'd14, 4'd1, 11'b1);
        clear_exp(); exp_c[0] = 1; push_rows(8);
        send(1'b1, 2'd2, 4'd0, 4'd1, 11'b1, w);
        chk("held_sym_wait", 128'(w), 128'(8));
        ac_sym(4'd0, 4'd0, 11'd0);
        wait_drain();
        chk("full_blk_err", 128'(err), 128'(0));

        // overflow past k=63: no write, block still emitted
        clear_exp(); exp_c[0] = 1; exp_c[54] = 1; push_rows(8);
        dc_sym(2'd2, 4'd0, 11'd0);
        repeat (3) ac_sym(4'd15, 4'd0, 11'd0);
        ac_sym(4'd10, 4'd1, 11'b1);
        ac_sym(4'd5, 4'd1, 11'b1);
        wait_drain();
        chk("overflow_err", 128'(err), 128'(1));

        // pred_clear with comp 1 DC, plus backpressure on row 4
        clear_exp(); exp_c[0] = 7; exp_c[12] = 3; exp_c[40] = -4; push_rows(8);
        bp_exp = row_data(4);
        pred_clear = 1'b1;
        dc_sym(2'd1, 4'd3, 11'b111);
        pred_clear = 1'b0;
        ac_sym(4'd15, 4'd2, 11'b11); ac_sym(4'd3, 4'd3, 11'b011); ac_sym(4'd0, 4'd0, 11'd0);
        wait_row(3'd4);
        out_ready = 1'b0;
        repeat (3) begin
            @(posedge clock); #1;
            chk("bp_valid", 128'(out_valid), 128'(1));
            chk("bp_row", 128'(out_row), 128'(4));
            chk("bp_data", 128'(out_data), 128'(bp_exp));
        end
        out_ready = 1'b1;
        wait_drain();

        clear_exp(); exp_c[0] = 1; push_rows(8);
        dc_sym(2'd0, 4'd1, 11'b1); ac_sym(4'd0, 4'd0, 11'd0);
        wait_drain();
        clear_exp(); exp_c[0] = 6; push_rows(8);
        dc_sym(2'd1, 4'd1, 11'b0); ac_sym(4'd0, 4'd0, 11'd0);
        wait_drain();
        chk("err_sticky", 128'(err), 128'(1));

        // reset during OUT at row 3 discards the rest of the block
        clear_exp(); exp_c[0] = 4; push_rows(3);
        dc_sym(2'd0, 4'd2, 11'b11); ac_sym(4'd0, 4'd0, 11'd0);
        wait_row(3'd3);
        reset = 1'b1;
        @(posedge clock); #1;
        chk("mid_rst_rows_seen", 128'(q.size()), 128'(0));
        chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
        chk("mid_rst_out_row", 128'(out_row), 128'(0));
        chk("mid_rst_out_last", 128'(out_last), 128'(0));
        chk("mid_rst_err", 128'(err), 128'(0));
        chk("mid_rst_out_data", 128'(out_data), 128'(0));
        chk("mid_rst_sym_ready", 128'(sym_ready), 128'(0));
        reset = 1'b0;
        @(posedge clock); #1;
        chk("post_rst_sym_ready", 128'(sym_ready), 128'(1));
        clear_exp(); exp_c[0] = 1; push_rows(8);
        dc_sym(2'd0, 4'd1, 11'b1); ac_sym(4'd0, 4'd0, 11'd0);
        wait_drain();
        chk("post_rst_err", 128'(err), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule
